// File: rtl/key_action_gen_pkg.sv
// key_pkg: shared types and defaults for the keycode -> game action path.
// Holds the action encoding, FSM state codes, default keycodes and the
// frame counter width used by key_action_gen.
package key_pkg;

    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_LEFT  = 3'd1,
        ACT_RIGHT = 3'd2,
        ACT_ROT   = 3'd3,
        ACT_DOWN  = 3'd4,
        ACT_DROP  = 3'd5
    } action_e;

    // FSM state codes kept as plain constants so older tools can read them
    typedef logic [1:0] kstate_e;
    localparam kstate_e IDLE   = 2'd0;
    localparam kstate_e DELAY  = 2'd1;
    localparam kstate_e REPEAT = 2'd2;
    localparam kstate_e HOLD   = 2'd3;

    // Default USB HID keycodes (WASD + Space)
    localparam logic [7:0] KC_LEFT_DEF  = 8'h04;
    localparam logic [7:0] KC_RIGHT_DEF = 8'h07;
    localparam logic [7:0] KC_ROT_DEF   = 8'h1A;
    localparam logic [7:0] KC_DOWN_DEF  = 8'h16;
    localparam logic [7:0] KC_DROP_DEF  = 8'h2C;

    localparam int CNT_W = 6;

    // Movement-style actions auto-repeat; rotate and hard drop fire once
    function automatic logic is_repeatable(input action_e a);
        return (a == ACT_LEFT) || (a == ACT_RIGHT) || (a == ACT_DOWN);
    endfunction

endpackage

// File: rtl/key_action_gen_frame_tick_sync.sv
// frame_tick_sync: brings the VGA frame strobe into the Clk domain and
// turns each rising edge into a single-cycle tick (3 Clk cycles latency).
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic frame_tick
);

    logic r_s1, r_s2, r_s3, r_tick;

    // Two-flop synchronizer, a delayed copy for edge detection, registered tick
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_s1   <= frame_clk;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_tick <= r_s2 & ~r_s3;
        end
    end

    assign frame_tick = r_tick;

endmodule

// File: rtl/key_action_gen.sv
// key_action_gen: turns the raw SoC keycode into one-cycle game action
// pulses with frame-based auto-repeat (DAS/ARR) for left, right and soft drop.
// Optional macro KEY_ACTION_COUNT_EN adds a 16-bit emitted-pulse counter.
module key_action_gen
    import key_pkg::*;
#(
    parameter int         DAS_FRAMES = 10,
    parameter int         ARR_FRAMES = 3,
    parameter logic [7:0] KC_LEFT    = KC_LEFT_DEF,
    parameter logic [7:0] KC_RIGHT   = KC_RIGHT_DEF,
    parameter logic [7:0] KC_ROT     = KC_ROT_DEF,
    parameter logic [7:0] KC_DOWN    = KC_DOWN_DEF,
    parameter logic [7:0] KC_DROP    = KC_DROP_DEF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    output logic        move_left,
    output logic        move_right,
    output logic        rotate,
    output logic        soft_drop,
    output logic        hard_drop,
    output logic [2:0]  held_action,
    output logic        frame_tick
`ifdef KEY_ACTION_COUNT_EN
    ,
    output logic [15:0] action_count
`endif
);

    localparam logic [CNT_W-1:0] LP_DAS = CNT_W'(DAS_FRAMES);
    localparam logic [CNT_W-1:0] LP_ARR = CNT_W'(ARR_FRAMES);

    logic [7:0]       r_keycode_q;
    action_e          w_act;
    logic             w_tick;
    kstate_e          r_state, w_state_nx;
    action_e          r_held, w_held_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic             w_fire;
    action_e          w_fire_act;
    logic             r_left, r_right, r_rot, r_down, r_drop;

    frame_tick_sync u_sync (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .frame_tick (w_tick)
    );

    // Single register stage on the keycode; also masks a key held through reset
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_keycode_q <= 8'h00;
        else          r_keycode_q <= keycode;
    end

    // Keycode decode; anything unmapped (including 00) means no action
    always_comb begin
        w_act = ACT_NONE;
        case (r_keycode_q)
            KC_LEFT:  w_act = ACT_LEFT;
            KC_RIGHT: w_act = ACT_RIGHT;
            KC_ROT:   w_act = ACT_ROT;
            KC_DOWN:  w_act = ACT_DOWN;
            KC_DROP:  w_act = ACT_DROP;
            default:  w_act = ACT_NONE;
        endcase
    end

    // Next state: release, then new press, then frame tick (lower items lose)
    always_comb begin
        w_state_nx = r_state;
        w_held_nx  = r_held;
        w_cnt_nx   = r_cnt;
        w_fire     = 1'b0;
        w_fire_act = r_held;
        w_cnt_inc  = r_cnt + CNT_W'(1);
        if (w_act == ACT_NONE) begin
            w_state_nx = IDLE;
            w_held_nx  = ACT_NONE;
            w_cnt_nx   = '0;
        end else if (w_act != r_held) begin
            w_fire     = 1'b1;
            w_fire_act = w_act;
            w_held_nx  = w_act;
            w_cnt_nx   = '0;
            w_state_nx = is_repeatable(w_act) ? DELAY : HOLD;
        end else if (w_tick) begin
            case (r_state)
                DELAY: begin
                    if (w_cnt_inc == LP_DAS) begin
                        w_fire     = 1'b1;
                        w_cnt_nx   = '0;
                        w_state_nx = REPEAT;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                REPEAT: begin
                    if (w_cnt_inc == LP_ARR) begin
                        w_fire   = 1'b1;
                        w_cnt_nx = '0;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM state, held action, frame counter and registered one-hot pulses
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_held  <= ACT_NONE;
            r_cnt   <= '0;
            r_left  <= 1'b0;
            r_right <= 1'b0;
            r_rot   <= 1'b0;
            r_down  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_held  <= w_held_nx;
            r_cnt   <= w_cnt_nx;
            r_left  <= w_fire && (w_fire_act == ACT_LEFT);
            r_right <= w_fire && (w_fire_act == ACT_RIGHT);
            r_rot   <= w_fire && (w_fire_act == ACT_ROT);
            r_down  <= w_fire && (w_fire_act == ACT_DOWN);
            r_drop  <= w_fire && (w_fire_act == ACT_DROP);
        end
    end

`ifdef KEY_ACTION_COUNT_EN
    logic [15:0] r_action_count;

    // Debug count of every emitted pulse, wrapping at 16 bits
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)    r_action_count <= 16'h0000;
        else if (w_fire) r_action_count <= r_action_count + 16'd1;
    end

    assign action_count = r_action_count;
`endif

    assign move_left   = r_left;
    assign move_right  = r_right;
    assign rotate      = r_rot;
    assign soft_drop   = r_down;
    assign hard_drop   = r_drop;
    assign held_action = r_held;
    assign frame_tick  = w_tick;

endmodule

// File: tb/tb_key_action_gen.sv
// tb_key_action_gen: directed bench for key_action_gen (DAS=10, ARR=3).
// Inputs are driven and outputs sampled 1 ns after each falling Clk edge.
module tb_key_action_gen;
    import key_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_clk;
    logic [7:0]  keycode;
    logic        move_left, move_right, rotate, soft_drop, hard_drop;
    logic [2:0]  held_action;
    logic        frame_tick;
`ifdef KEY_ACTION_COUNT_EN
    logic [15:0] action_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int n_l = 0, n_r = 0, n_rot = 0, n_d = 0, n_h = 0, n_multi = 0;
    int b0, b1, b_tot;

    key_action_gen dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .keycode      (keycode),
        .move_left    (move_left),
        .move_right   (move_right),
        .rotate       (rotate),
        .soft_drop    (soft_drop),
        .hard_drop    (hard_drop),
        .held_action  (held_action),
        .frame_tick   (frame_tick)
`ifdef KEY_ACTION_COUNT_EN
        ,
        .action_count (action_count)
`endif
    );

    always #5 Clk = ~Clk;

    // Pulse tally per output plus a count of cycles with more than one pulse
    always @(negedge Clk) begin
        n_l   <= n_l   + int'(move_left);
        n_r   <= n_r   + int'(move_right);
        n_rot <= n_rot + int'(rotate);
        n_d   <= n_d   + int'(soft_drop);
        n_h   <= n_h   + int'(hard_drop);
        if ($countones({move_left, move_right, rotate, soft_drop, hard_drop}) > 1)
            n_multi <= n_multi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge Clk);
            #1;
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            cyc(4);
            frame_clk = 1'b0;
            cyc(4);
        end
    endtask

    function automatic int tot();
        return n_l + n_r + n_rot + n_d + n_h;
    endfunction

    initial begin
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        keycode   = 8'h04;
        cyc(3);
        chk("rst_left", 32'(move_left), 0);
        chk("rst_held", 32'(held_action), 32'(ACT_NONE));
        chk("rst_tick", 32'(frame_tick), 0);

        // Key held across reset release: one fresh press, 2 cycles later
        b0 = n_l;
        Reset_n = 1'b1;
        cyc(1);
        chk("rel_c1_left", 32'(move_left), 0);
        cyc(1);
        chk("rel_c2_left", 32'(move_left), 1);
        chk("rel_c2_held", 32'(held_action), 32'(ACT_LEFT));
        cyc(1);
        chk("rel_c3_left", 32'(move_left), 0);
        chk("rel_cnt", 32'(n_l - b0), 1);

        // DAS/ARR on a held left key: repeats at ticks 10, 13, 16, 19
        frames(9);
        chk("das_9", 32'(n_l - b0), 1);
        frames(1);
        chk("das_10", 32'(n_l - b0), 2);
        frames(2);
        chk("arr_12", 32'(n_l - b0), 2);
        frames(1);
        chk("arr_13", 32'(n_l - b0), 3);
        frames(7);
        chk("arr_20", 32'(n_l - b0), 5);
        chk("left_only", 32'(tot() - n_l), 0);
        keycode = 8'h00;
        cyc(2);
        chk("left_release", 32'(held_action), 32'(ACT_NONE));

        // Unmapped keycode does nothing
        b0 = tot();
        keycode = 8'h05;
        cyc(2);
        chk("unmapped_held", 32'(held_action), 32'(ACT_NONE));
        frames(11);
        chk("unmapped_pulses", 32'(tot() - b0), 0);
        keycode = 8'h00;
        cyc(2);

        // Rotate fires once and stays held
        b0 = n_rot;
        keycode = 8'h1A;
        cyc(2);
        chk("rot_pulse", 32'(rotate), 1);
        frames(20);
        chk("rot_count", 32'(n_rot - b0), 1);
        chk("rot_held", 32'(held_action), 32'(ACT_ROT));
        keycode = 8'h00;
        cyc(1);
        chk("rot_rel_c1", 32'(held_action), 32'(ACT_ROT));
        cyc(1);
        chk("rot_rel_c2", 32'(held_action), 32'(ACT_NONE));

        // Direct switch left -> right restarts the delay
        keycode = 8'h04;
        cyc(2);
        frames(5);
        b0 = n_l;
        b1 = n_r;
        keycode = 8'h07;
        cyc(2);
        chk("sw_right_pulse", 32'(move_right), 1);
        frames(9);
        chk("sw_right_9", 32'(n_r - b1), 1);
        chk("sw_no_left", 32'(n_l - b0), 0);
        frames(1);
        chk("sw_right_10", 32'(n_r - b1), 2);
        keycode = 8'h00;
        cyc(2);

        // Soft drop press coinciding with a frame tick: that tick is not counted
        frame_clk = 1'b1;
        cyc(2);
        chk("tick_lat2", 32'(frame_tick), 0);
        keycode = 8'h16;
        cyc(1);
        chk("tick_lat3", 32'(frame_tick), 1);
        chk("coin_c1_down", 32'(soft_drop), 0);
        cyc(1);
        chk("coin_c2_down", 32'(soft_drop), 1);
        chk("tick_width", 32'(frame_tick), 0);
        cyc(2);
        frame_clk = 1'b0;
        cyc(4);
        b0 = n_d;
        frames(9);
        chk("coin_9", 32'(n_d - b0), 0);
        frames(1);
        chk("coin_10", 32'(n_d - b0), 1);
        keycode = 8'h00;
        cyc(2);

        // Hard drop: single pulse
        b0 = n_h;
        keycode = 8'h2C;
        cyc(2);
        chk("drop_pulse", 32'(hard_drop), 1);
        frames(4);
        chk("drop_count", 32'(n_h - b0), 1);
        keycode = 8'h00;
        cyc(2);

        // Reset mid-REPEAT while a repeat pulse is on the output
        keycode = 8'h07;
        cyc(2);
        frames(12);
        frame_clk = 1'b1;
        cyc(4);
        chk("mid_pulse", 32'(move_right), 1);
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_right", 32'(move_right), 0);
        chk("mid_rst_held", 32'(held_action), 32'(ACT_NONE));
        chk("mid_rst_tick", 32'(frame_tick), 0);
`ifdef KEY_ACTION_COUNT_EN
        chk("mid_rst_count", 32'(action_count), 0);
`endif
        frame_clk = 1'b0;
        cyc(3);
        b1 = n_r;
        b_tot = tot();
        Reset_n = 1'b1;
        cyc(2);
        chk("post_rst_pulse", 32'(move_right), 1);
        frames(9);
        chk("post_rst_9", 32'(n_r - b1), 1);
        frames(1);
        chk("post_rst_10", 32'(n_r - b1), 2);
`ifdef KEY_ACTION_COUNT_EN
        chk("count_total", 32'(action_count), 32'(tot() - b_tot));
`endif
        keycode = 8'h00;
        cyc(2);

        chk("one_hot", 32'(n_multi), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_action_gen.md
Name: key_action_gen

Overview:
- Converts the raw 8-bit USB HID keycode from the SoC keycode PIO into one-cycle game-action pulses (left, right, rotate, soft drop, hard drop).
- Left, right and soft drop auto-repeat: they repeat after an initial delay, then at a fixed rate, counted in video frames.
- Sits between the SoC `keycode_export` and the piece/ball motion logic. It uses the frame strobe that the motion logic already receives (the inverted VGA_VS).

Parameters:
- DAS_FRAMES, 10: frame ticks from press to first auto-repeat pulse. Legal range 1..63.
- ARR_FRAMES, 3: frame ticks between subsequent repeat pulses. Legal range 1..63.
- KC_LEFT, 8'h04: keycode for left (A).
- KC_RIGHT, 8'h07: keycode for right (D).
- KC_ROT, 8'h1A: keycode for rotate (W).
- KC_DOWN, 8'h16: keycode for soft drop (S).
- KC_DROP, 8'h2C: keycode for hard drop (Space).

Ports:
- Clk, input, 1: system clock (MAX10_CLK1_50).
- Reset_n, input, 1: asynchronous, active-low reset.
- frame_clk, input, 1: frame strobe (~VGA_VS); asynchronous to Clk.
- keycode, input, 8: raw keycode from the SoC; 8'h00 means no key.
- move_left, output, 1: one-cycle pulse.
- move_right, output, 1: one-cycle pulse.
- rotate, output, 1: one-cycle pulse.
- soft_drop, output, 1: one-cycle pulse.
- hard_drop, output, 1: one-cycle pulse.
- held_action, output, 3: action_e of the currently held action; ACT_NONE when idle.
- frame_tick, output, 1: one-cycle pulse per frame, exported for downstream use.

Behaviour:
- **Reset.** Clk is the single clock. Reset_n is asynchronous and active-low. While Reset_n is low:
  - all pulse outputs are 0;
  - held_action = ACT_NONE;
  - frame_tick = 0;
  - FSM is IDLE, counter = 0, synchronizer flops = 0.
  - Release from reset produces no spurious pulse, even if a key is already held. That key is treated as a fresh press 2 cycles later.
- **Frame tick.**
  - frame_clk passes through a 2-flop synchronizer, then a rising-edge detector.
  - frame_tick is high for exactly 1 Clk cycle per frame_clk rising edge.
  - Latency from the frame_clk edge is 3 Clk cycles.
- **Decode.**
  - keycode is registered once into keycode_q.
  - keycode_q is decoded combinationally into action_e. 8'h00 and any unmapped code decode to ACT_NONE.
  - Repeatable actions: LEFT, RIGHT, DOWN. Single-shot actions: ROT, DROP.
- **FSM states:** IDLE, DELAY, REPEAT, HOLD. A 6-bit frame counter is used in DELAY and REPEAT.
- **New press.** A new press is defined as decoded action != ACT_NONE and != held_action. Evaluated in any state:
  - emit the pulse for that action;
  - set held_action;
  - clear the counter;
  - go to DELAY if the action is repeatable, otherwise HOLD.
- **DELAY.**
  - Each frame_tick increments the counter.
  - When the count reaches DAS_FRAMES: emit a repeat pulse, clear the counter, go to REPEAT.
- **REPEAT.**
  - Each frame_tick increments the counter.
  - When the count reaches ARR_FRAMES: emit a pulse and clear the counter. Stay in REPEAT.
- **HOLD.** No further pulses while the same key is held.
- **Release.** Decoded action = ACT_NONE → go to IDLE, held_action = ACT_NONE, no pulse.
- **Priorities (same-cycle events).**
  - A new press wins over a frame_tick arriving in the same cycle; that tick is not counted.
  - A release wins over a frame_tick arriving in the same cycle.
- **Pulse timing.**
  - Latency is 2 Clk cycles from the keycode input change to the pulse output.
  - Every pulse output is registered.
  - At most one pulse output is high in any cycle.
- **Key switch.** Switching keys directly (e.g. LEFT to RIGHT with no 00 in between) is a new press. The old action never produces another pulse.
- **Reset mid-operation.** Reset aborts immediately: outputs go to 0 asynchronously and any pending repeat is discarded.

Optional Feature:
- Macro: KEY_ACTION_COUNT_EN.
- Defined:
  - adds output `action_count`, 16 bits;
  - it increments by 1 on every emitted pulse (initial or repeat) and wraps from 16'hFFFF to 0;
  - reset value is 0;
  - intended for the HEX displays during debug.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package `key_pkg` holds:
  - `action_e` (3-bit enum: ACT_NONE, ACT_LEFT, ACT_RIGHT, ACT_ROT, ACT_DOWN, ACT_DROP);
  - `kstate_e` (IDLE, DELAY, REPEAT, HOLD);
  - the default keycode localparams;
  - the 6-bit counter width constant.
- Sub-module `frame_tick_sync`: the 2-flop synchronizer plus rising-edge detector. Ports: Clk, Reset_n, frame_clk, frame_tick.

Test Plan:
- Reset with keycode=8'h04 held, then release Reset_n → exactly one move_left pulse, 2 cycles after release; no other pulses.
- Hold 8'h04 for 20 frame ticks (DAS=10, ARR=3) → 5 move_left pulses: at press, then at ticks 10, 13, 16, 19.
- Hold 8'h1A for 20 frame ticks → exactly 1 rotate pulse; held_action = ACT_ROT throughout; keycode 8'h00 → held_action = ACT_NONE 2 cycles later.
- Hold 8'h04 for 5 ticks, then switch directly to 8'h07 → move_right pulse 2 cycles after the switch; no further move_left; first right repeat at tick 10 after the switch.
- New press of 8'h16 and a frame_tick in the same cycle → soft_drop pulse; the counter stays 0, so the first repeat comes at the 10th subsequent tick, not the 9th.
- Assert Reset_n low mid-REPEAT while holding 8'h07 → all outputs 0 immediately; with KEY_ACTION_COUNT_EN, action_count reads 0.
